// File: rtl/wb_bus_arbiter_if.sv
// Bundle of every bus signal around the two-master wishbone arbiter.
// The "slave" modport is the arbiter's own view: it answers the two CPU
// masters and drives the shared memory/peripheral bus.
// The "master" modport is the surrounding system: the CPU ports plus the memory bus.
interface wb_bus_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int SW = 4
);
    // master 0: instruction fetch
    logic          m0_cyc_in;
    logic          m0_stb_in;
    logic          m0_we_in;
    logic [AW-1:0] m0_adr_in;
    logic [DW-1:0] m0_data_in;
    logic [SW-1:0] m0_sel_in;
    logic          m0_ack_out;
    logic          m0_err_out;
    logic [DW-1:0] m0_data_out;
    // master 1: load/store
    logic          m1_cyc_in;
    logic          m1_stb_in;
    logic          m1_we_in;
    logic [AW-1:0] m1_adr_in;
    logic [DW-1:0] m1_data_in;
    logic [SW-1:0] m1_sel_in;
    logic          m1_ack_out;
    logic          m1_err_out;
    logic [DW-1:0] m1_data_out;
    // shared slave bus
    logic          s_cyc_out;
    logic          s_stb_out;
    logic          s_we_out;
    logic [AW-1:0] s_adr_out;
    logic [DW-1:0] s_data_out;
    logic [SW-1:0] s_sel_out;
    logic          s_ack_in;
    logic [DW-1:0] s_data_in;
    // one-hot grant {m1,m0}
    logic [1:0]    gnt_out;

    modport slave (
        input  m0_cyc_in, m0_stb_in, m0_we_in, m0_adr_in, m0_data_in, m0_sel_in,
        output m0_ack_out, m0_err_out, m0_data_out,
        input  m1_cyc_in, m1_stb_in, m1_we_in, m1_adr_in, m1_data_in, m1_sel_in,
        output m1_ack_out, m1_err_out, m1_data_out,
        output s_cyc_out, s_stb_out, s_we_out, s_adr_out, s_data_out, s_sel_out,
        input  s_ack_in, s_data_in,
        output gnt_out
    );

    modport master (
        output m0_cyc_in, m0_stb_in, m0_we_in, m0_adr_in, m0_data_in, m0_sel_in,
        input  m0_ack_out, m0_err_out, m0_data_out,
        output m1_cyc_in, m1_stb_in, m1_we_in, m1_adr_in, m1_data_in, m1_sel_in,
        input  m1_ack_out, m1_err_out, m1_data_out,
        input  s_cyc_out, s_stb_out, s_we_out, s_adr_out, s_data_out, s_sel_out,
        output s_ack_in, s_data_in,
        input  gnt_out
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin wishbone arbiter with a per-transfer ack watchdog.
// m0 (instruction fetch) and m1 (load/store) share one slave bus. The owner
// keeps the bus until it drops cyc; a strobe that waits TIMEOUT cycles for an
// ack is failed back to its master with a one-cycle error pulse.
module wb_bus_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int SW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    wb_bus_arbiter_if.slave      bus
);
    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t         r_state;
    logic [1:0]     r_gnt;
    logic           r_last;
    logic [WDW-1:0] r_wdog;

    logic           w_g_cyc;
    logic           w_g_stb;
    logic           w_g_we;
    logic [AW-1:0]  w_g_adr;
    logic [DW-1:0]  w_g_data;
    logic [SW-1:0]  w_g_sel;
    logic           w_busy;
    logic           w_err;

    // Select the request signals of whichever master currently holds the grant.
    always_comb begin
        w_g_cyc  = 1'b0;
        w_g_stb  = 1'b0;
        w_g_we   = 1'b0;
        w_g_adr  = '0;
        w_g_data = '0;
        w_g_sel  = '0;
        if (r_gnt[1]) begin
            w_g_cyc  = bus.m1_cyc_in;
            w_g_stb  = bus.m1_stb_in;
            w_g_we   = bus.m1_we_in;
            w_g_adr  = bus.m1_adr_in;
            w_g_data = bus.m1_data_in;
            w_g_sel  = bus.m1_sel_in;
        end else if (r_gnt[0]) begin
            w_g_cyc  = bus.m0_cyc_in;
            w_g_stb  = bus.m0_stb_in;
            w_g_we   = bus.m0_we_in;
            w_g_adr  = bus.m0_adr_in;
            w_g_data = bus.m0_data_in;
            w_g_sel  = bus.m0_sel_in;
        end else begin
            w_g_cyc  = 1'b0;
        end
    end

    // Timeout fires on the last permitted wait cycle unless the ack arrives then.
    always_comb begin
        w_busy = (r_state == ST_BUSY);
        w_err  = w_busy & w_g_stb & ~bus.s_ack_in & (r_wdog == WDW'(TIMEOUT - 1));
    end

    // Drive the slave bus only while a transfer is live; route acks/data/errors back.
    always_comb begin
        bus.s_cyc_out  = 1'b0;
        bus.s_stb_out  = 1'b0;
        bus.s_we_out   = 1'b0;
        bus.s_adr_out  = '0;
        bus.s_data_out = '0;
        bus.s_sel_out  = '0;
        if (w_busy) begin
            bus.s_cyc_out  = w_g_cyc;
            bus.s_stb_out  = w_g_stb;
            bus.s_we_out   = w_g_we;
            bus.s_adr_out  = w_g_adr;
            bus.s_data_out = w_g_data;
            bus.s_sel_out  = w_g_sel;
        end else begin
            bus.s_cyc_out  = 1'b0;
        end
        bus.m0_ack_out  = w_busy & bus.s_ack_in & r_gnt[0] & bus.m0_stb_in;
        bus.m1_ack_out  = w_busy & bus.s_ack_in & r_gnt[1] & bus.m1_stb_in;
        bus.m0_err_out  = w_err & r_gnt[0];
        bus.m1_err_out  = w_err & r_gnt[1];
        bus.m0_data_out = r_gnt[0] ? bus.s_data_in : '0;
        bus.m1_data_out = r_gnt[1] ? bus.s_data_in : '0;
        bus.gnt_out     = r_gnt;
    end

    // Arbitration FSM: grant, hold until cyc drops, count ack waits, park on error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
            r_wdog  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wdog <= '0;
                    if (bus.m0_cyc_in && bus.m1_cyc_in) begin
                        // tie: the master that did not win last time goes first
                        r_state <= ST_BUSY;
                        if (r_last) begin
                            r_gnt  <= 2'b01;
                            r_last <= 1'b0;
                        end else begin
                            r_gnt  <= 2'b10;
                            r_last <= 1'b1;
                        end
                    end else if (bus.m0_cyc_in) begin
                        r_state <= ST_BUSY;
                        r_gnt   <= 2'b01;
                        r_last  <= 1'b0;
                    end else if (bus.m1_cyc_in) begin
                        r_state <= ST_BUSY;
                        r_gnt   <= 2'b10;
                        r_last  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 2'b00;
                    end
                end
                ST_BUSY: begin
                    if (w_err) begin
                        r_state <= ST_ERR;
                        r_wdog  <= '0;
                    end else if (!w_g_cyc) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 2'b00;
                        r_wdog  <= '0;
                    end else if (w_g_stb && !bus.s_ack_in) begin
                        r_wdog  <= r_wdog + WDW'(1);
                    end else begin
                        r_wdog  <= '0;
                    end
                end
                ST_ERR: begin
                    r_wdog <= '0;
                    if (!w_g_cyc) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 2'b00;
                    end else begin
                        r_state <= ST_ERR;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                    r_last  <= 1'b1;
                    r_wdog  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: a bus-ownership model checks every
// output on every falling edge, and directed scenarios pin key values by hand.
module tb_wb_bus_arbiter;
    localparam int TO = 8;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    wb_bus_arbiter_if #(.AW(16), .DW(16), .SW(4)) bus ();

    wb_bus_arbiter #(.AW(16), .DW(16), .SW(4), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 nobody, 0/1 master index; failed: owner timed out, bus parked
    int          m_own   = -1;
    bit          m_fail  = 1'b0;
    int          m_wait  = 0;
    int          m_last  = 1;
    bit          m_valid = 1'b0;
    bit          o_cyc, o_stb, o_we, o_act, e_err;
    logic [15:0] o_adr, o_dat;
    logic [3:0]  o_sel;

    always @(negedge clk) begin
        if (m_own == 0) begin
            o_cyc = bus.m0_cyc_in; o_stb = bus.m0_stb_in; o_we = bus.m0_we_in;
            o_adr = bus.m0_adr_in; o_dat = bus.m0_data_in; o_sel = bus.m0_sel_in;
        end else if (m_own == 1) begin
            o_cyc = bus.m1_cyc_in; o_stb = bus.m1_stb_in; o_we = bus.m1_we_in;
            o_adr = bus.m1_adr_in; o_dat = bus.m1_data_in; o_sel = bus.m1_sel_in;
        end else begin
            o_cyc = 1'b0; o_stb = 1'b0; o_we = 1'b0;
            o_adr = 16'h0; o_dat = 16'h0; o_sel = 4'h0;
        end
        o_act = (m_own >= 0) && !m_fail;
        e_err = o_act && o_stb && !bus.s_ack_in && (m_wait == TO - 1);
        if (m_valid) begin
            chk("s_cyc",   32'(bus.s_cyc_out),  32'(o_act && o_cyc));
            chk("s_stb",   32'(bus.s_stb_out),  32'(o_act && o_stb));
            chk("s_we",    32'(bus.s_we_out),   32'(o_act && o_we));
            chk("s_adr",   32'(bus.s_adr_out),  o_act ? 32'(o_adr) : 32'd0);
            chk("s_data",  32'(bus.s_data_out), o_act ? 32'(o_dat) : 32'd0);
            chk("s_sel",   32'(bus.s_sel_out),  o_act ? 32'(o_sel) : 32'd0);
            chk("m0_ack",  32'(bus.m0_ack_out), 32'(o_act && m_own == 0 && bus.s_ack_in && bus.m0_stb_in));
            chk("m1_ack",  32'(bus.m1_ack_out), 32'(o_act && m_own == 1 && bus.s_ack_in && bus.m1_stb_in));
            chk("m0_err",  32'(bus.m0_err_out), 32'(e_err && m_own == 0));
            chk("m1_err",  32'(bus.m1_err_out), 32'(e_err && m_own == 1));
            chk("m0_data", 32'(bus.m0_data_out), (m_own == 0) ? 32'(bus.s_data_in) : 32'd0);
            chk("m1_data", 32'(bus.m1_data_out), (m_own == 1) ? 32'(bus.s_data_in) : 32'd0);
            chk("gnt",     32'(bus.gnt_out),    (m_own < 0) ? 32'd0 : (32'd1 << m_own));
        end
        // advance to the state expected after the coming rising edge
        if (!reset) begin
            m_own = -1; m_fail = 1'b0; m_wait = 0; m_last = 1; m_valid = 1'b1;
        end else if (m_own < 0) begin
            m_wait = 0;
            if (bus.m0_cyc_in && bus.m1_cyc_in) m_own = 1 - m_last;
            else if (bus.m0_cyc_in)             m_own = 0;
            else if (bus.m1_cyc_in)             m_own = 1;
            else                                m_own = -1;
            if (m_own >= 0) m_last = m_own;
        end else if (m_fail) begin
            m_wait = 0;
            if (!o_cyc) begin m_own = -1; m_fail = 1'b0; end
        end else if (e_err) begin
            m_fail = 1'b1; m_wait = 0;
        end else if (!o_cyc) begin
            m_own = -1; m_wait = 0;
        end else if (o_stb && !bus.s_ack_in) begin
            m_wait = m_wait + 1;
        end else begin
            m_wait = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); endtask

    task automatic drive_m0(input bit c, input bit s, input bit w,
                            input logic [15:0] a, input logic [15:0] d, input logic [3:0] sl);
        bus.m0_cyc_in = c; bus.m0_stb_in = s; bus.m0_we_in = w;
        bus.m0_adr_in = a; bus.m0_data_in = d; bus.m0_sel_in = sl;
    endtask

    task automatic drive_m1(input bit c, input bit s, input bit w,
                            input logic [15:0] a, input logic [15:0] d, input logic [3:0] sl);
        bus.m1_cyc_in = c; bus.m1_stb_in = s; bus.m1_we_in = w;
        bus.m1_adr_in = a; bus.m1_data_in = d; bus.m1_sel_in = sl;
    endtask

    task automatic quiet();
        drive_m0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
        bus.s_ack_in  = 1'b0;
        bus.s_data_in = 16'h0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b0;
        quiet();
        nxt(); nxt();
        mid(); chk("rst_gnt", 32'(bus.gnt_out), 32'd0); chk("rst_cyc", 32'(bus.s_cyc_out), 32'd0);
        nxt(); reset = 1'b1;

        // 1: m0 read 0x1234, ack on the third strobed cycle with 0xBEEF
        nxt(); drive_m0(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0, 4'hF); mid();
        nxt(); mid();
        chk("t1_stb", 32'(bus.s_stb_out), 32'd1);
        chk("t1_adr", 32'(bus.s_adr_out), 32'h1234);
        nxt(); mid();
        nxt(); bus.s_ack_in = 1'b1; bus.s_data_in = 16'hBEEF; mid();
        chk("t1_ack",  32'(bus.m0_ack_out),  32'd1);
        chk("t1_data", 32'(bus.m0_data_out), 32'hBEEF);
        chk("t1_ack1", 32'(bus.m1_ack_out),  32'd0);
        nxt(); quiet(); mid();
        nxt(); mid();

        // 2: tie after reset -> m0, dead cycle, m1, next tie -> m0
        nxt(); reset = 1'b0;
        nxt(); reset = 1'b1;
        nxt(); drive_m0(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
               drive_m1(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0); mid();
        chk("t2_idle", 32'(bus.gnt_out), 32'd0);
        nxt(); mid(); chk("t2_g0", 32'(bus.gnt_out), 32'd1);
        nxt(); drive_m0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0); mid();
        chk("t2_hold", 32'(bus.gnt_out), 32'd1);
        nxt(); mid(); chk("t2_dead", 32'(bus.gnt_out), 32'd0);
        nxt(); mid(); chk("t2_g1", 32'(bus.gnt_out), 32'd2);
        nxt(); drive_m1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0); mid();
        nxt(); mid();
        nxt(); drive_m0(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
               drive_m1(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0); mid();
        nxt(); mid(); chk("t2_tie2", 32'(bus.gnt_out), 32'd1);
        nxt(); quiet(); mid();
        nxt(); mid();

        // 3: m1 write to a silent slave -> error on the 8th strobed cycle
        nxt(); drive_m1(1'b1, 1'b1, 1'b1, 16'h0040, 16'h00A5, 4'hF); mid();
        for (int k = 1; k <= TO; k++) begin
            nxt(); mid();
            chk("t3_err", 32'(bus.m1_err_out), 32'(k == TO));
            if (k == 1) begin
                chk("t3_adr", 32'(bus.s_adr_out),  32'h0040);
                chk("t3_dat", 32'(bus.s_data_out), 32'h00A5);
            end
        end
        nxt(); bus.s_ack_in = 1'b1; mid();
        chk("t3_cyc",  32'(bus.s_cyc_out),  32'd0);
        chk("t3_late", 32'(bus.m1_ack_out), 32'd0);
        chk("t3_err1", 32'(bus.m1_err_out), 32'd0);
        nxt(); bus.s_ack_in = 1'b0; drive_m1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0); mid();
        nxt(); mid(); chk("t3_idle", 32'(bus.gnt_out), 32'd0);

        // 4: m0 burst of three acked strobes while m1 keeps requesting
        nxt(); drive_m0(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0, 4'hF);
               drive_m1(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0, 4'hF); mid();
        for (int k = 0; k < 3; k++) begin
            nxt(); bus.s_ack_in = 1'b1; bus.s_data_in = 16'h5A00 + 16'(k);
            bus.m0_adr_in = 16'h0100 + 16'(k); mid();
            chk("t4_gnt",  32'(bus.gnt_out),    32'd1);
            chk("t4_ack0", 32'(bus.m0_ack_out), 32'd1);
            chk("t4_ack1", 32'(bus.m1_ack_out), 32'd0);
        end
        nxt(); bus.s_ack_in = 1'b0; drive_m0(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0); mid();
        chk("t4_hold", 32'(bus.gnt_out), 32'd1);
        nxt(); mid(); chk("t4_dead", 32'(bus.gnt_out), 32'd0);
        nxt(); bus.s_ack_in = 1'b1; bus.s_data_in = 16'h7777; mid();
        chk("t4_g1",   32'(bus.gnt_out),     32'd2);
        chk("t4_m1a",  32'(bus.m1_ack_out),  32'd1);
        chk("t4_m1d",  32'(bus.m1_data_out), 32'h7777);
        chk("t4_adr",  32'(bus.s_adr_out),   32'h0200);
        nxt(); quiet(); mid();
        nxt(); mid();

        // 5: reset in the middle of an m0 transfer, then a tie goes to m0
        nxt(); drive_m0(1'b1, 1'b1, 1'b1, 16'h0300, 16'h1111, 4'h3); mid();
        nxt(); reset = 1'b0; mid();
        chk("t5_stb", 32'(bus.s_stb_out), 32'd1);
        nxt(); reset = 1'b1; drive_m1(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0); mid();
        chk("t5_stb0", 32'(bus.s_stb_out),  32'd0);
        chk("t5_cyc0", 32'(bus.s_cyc_out),  32'd0);
        chk("t5_gnt0", 32'(bus.gnt_out),    32'd0);
        chk("t5_ack0", 32'(bus.m0_ack_out), 32'd0);
        nxt(); mid(); chk("t5_tie", 32'(bus.gnt_out), 32'd1);
        nxt(); quiet(); mid();
        nxt(); mid();

        // 6: ack lands exactly on the timeout cycle -> ack wins, stay busy
        nxt(); drive_m0(1'b1, 1'b1, 1'b0, 16'h0400, 16'h0, 4'hF); mid();
        for (int k = 1; k <= TO; k++) begin
            nxt();
            if (k == TO) begin bus.s_ack_in = 1'b1; bus.s_data_in = 16'hC0DE; end
            mid();
        end
        chk("t6_ack",  32'(bus.m0_ack_out),  32'd1);
        chk("t6_err",  32'(bus.m0_err_out),  32'd0);
        chk("t6_data", 32'(bus.m0_data_out), 32'hC0DE);
        nxt(); bus.s_ack_in = 1'b0; mid();
        chk("t6_cyc",  32'(bus.s_cyc_out),  32'd1);
        chk("t6_gnt",  32'(bus.gnt_out),    32'd1);
        chk("t6_err1", 32'(bus.m0_err_out), 32'd0);
        nxt(); quiet(); mid();
        nxt(); mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
